uart_byte_rx: RTL and testbench
===============================

# uart_byte_rx

Receive-side counterpart of the team's UART byte transmitter. Deserialises 8N1 frames (start bit, 8 data bits LSB first, stop bit) from the serial line into bytes. Holds each byte for the consumer under a valid/ack handshake, and reports framing and overrun errors. Sits between the board Rxd pin (or a transmitter's Txd in loopback) and the byte consumer.

## Interface
- CYCLES_PER_BIT, 10417 — clocks per bit. Equals the transmitter's bit period: terminal count 10416, so 10417 cycles, 9600 baud at 100 MHz. Must be ≥ 16.
- HALF_BIT, CYCLES_PER_BIT/2 (5208) — clocks from the detected start edge to mid-start-bit.
- SAMPLE_OFFSET, CYCLES_PER_BIT/16 (651) — spacing of the majority samples. Used only with the majority macro.
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset, asynchronous, active-low. Asserting it (0) clears all state immediately.
- Rxd  input  1  serial line, idle high; asynchronous to clk.
- rx_ack  input  1  consumer accepts the held byte. Acts on a cycle where rx_valid=1; ignored otherwise.
- rx_data  output  8  last good byte received; reset 0x00.
- rx_valid  output  1  rx_data holds an unaccepted byte; reset 0.
- frame_err  output  1  one-cycle pulse when a stop bit samples low; reset 0.
- overrun  output  1  one-cycle pulse when a good frame completes while rx_valid=1 and rx_ack=0; reset 0.
- busy  output  1  high in every state except IDLE; reset 0.

## Operation
- Rxd passes through a 2-flop synchroniser, reset value 1. All logic uses the synchronised signal rxs.
- State IDLE: on a falling edge of rxs (previous 1, current 0), load the bit timer with HALF_BIT-1 and go to START.
- State START: at timer expiry, sample rxs.
  - If 1: false start, return to IDLE with no outputs.
  - If 0: go to DATA; bit index 0; timer reload CYCLES_PER_BIT-1.
- State DATA: at each timer expiry, shift the sample into an 8-bit shift register from the MSB side, so bit 0 arrives first. After index 7, go to STOP.
- State STOP: at timer expiry, sample rxs.
  - If 1: good frame. Go to IDLE in the same cycle, so the next start edge can be caught immediately.
  - If 0: pulse frame_err, discard the byte, go to BREAK.
- State BREAK: wait until rxs=1, then go to IDLE. A held-low line (break) produces exactly one frame_err.
- Good frame with rx_valid=0, or with rx_ack=1 in the same cycle: rx_data ← shift register, rx_valid=1.
- Good frame with rx_valid=1 and rx_ack=0: new byte discarded, rx_data unchanged, overrun pulses.
- rx_ack with rx_valid=1 and no simultaneous good frame: rx_valid → 0 next cycle; rx_data retained.
- Bit timer: 14-bit down-counter; "expiry" means the timer is at 0. Bit index: 3 bits.
- No sample is ever taken in IDLE or BREAK.

## Timing
- Reset (rst=0) mid-frame: state → IDLE, partial byte lost, all outputs → reset values. Synchroniser flops → 1, so a line already low at release is not seen as a start edge.
- Latency, macro off: rx_valid rises 2 + HALF_BIT + 9·CYCLES_PER_BIT + 1 clocks after the Rxd falling edge (±1 clock for synchroniser phase). At defaults: 98964 ±1.
- rx_valid, rx_data, frame_err and overrun are registered outputs. frame_err and overrun are exactly one clock wide.
- Back-to-back frames (stop bit followed directly by the next start) are received without loss: IDLE is re-entered at mid-stop-bit.
- Tolerates ±4% baud mismatch with the sender.

## Configuration
- UART_RX_MAJORITY_EN defined: each bit, including start and stop, is decided by a 2-of-3 vote.
  - Samples are taken at mid−SAMPLE_OFFSET, mid, and mid+SAMPLE_OFFSET.
  - The decision is made at mid+SAMPLE_OFFSET, so every sample point and the rx_valid latency shift later by SAMPLE_OFFSET (defaults: 99615 ±1).
  - Subsequent bit timing stays anchored to the nominal mid-bit, so no cumulative drift.
- UART_RX_MAJORITY_EN undefined: a single sample at mid-bit; the vote logic is absent.

## Test plan
- Send 0xA5 at CYCLES_PER_BIT spacing → rx_valid=1 with rx_data=0xA5 at 98964 ±1 clocks. Pulse rx_ack → rx_valid=0 next cycle.
- Send 0x00 then 0xFF back-to-back, acking each within 1000 clocks → both bytes delivered in order; frame_err and overrun never pulse.
- Drive Rxd low for 2000 clocks, then high → no rx_valid, no frame_err; busy returns to 0 and a following 0x3C is received correctly.
- Send 0x81 with the stop bit low, then hold Rxd low for 5 bit times → exactly one frame_err pulse; rx_valid stays 0; the next 0x42 is received.
- Receive 0x11 without ack, then 0x22 → one overrun pulse; rx_data stays 0x11. Repeat with rx_ack asserted in the completion cycle → rx_data=0x22, no overrun.
- Assert rst (0) at data bit 4 of a frame → all outputs 0 immediately. After release, a fresh 0x5A is received correctly. With UART_RX_MAJORITY_EN, a 300-clock low glitch at mid-bit of a 1 bit → the bit is still received as 1.

Source files
------------

// File: rtl/uart_byte_rx.sv
// rtl/uart_byte_rx.sv - 8N1 UART byte receiver with valid/ack hand-off, framing and overrun pulses
// Optional 2-of-3 bit vote around mid-bit: define UART_RX_MAJORITY_EN.
module uart_byte_rx #(
  parameter int unsigned CYCLES_PER_BIT = 10417,
  parameter int unsigned HALF_BIT       = CYCLES_PER_BIT / 2,
  parameter int unsigned SAMPLE_OFFSET  = CYCLES_PER_BIT / 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Rxd,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  localparam logic [13:0] BIT_RELOAD  = 14'(CYCLES_PER_BIT - 1);
  localparam logic [13:0] HALF_RELOAD = 14'(HALF_BIT - 1);

  state_t      state_q;
  logic        sync1_q, rxs_q, rxs_prev_q;
  logic [13:0] timer_q;
  logic [2:0]  idx_q;
  logic [7:0]  shift_q, data_q;
  logic        valid_q, ferr_q, ovr_q;
  logic        mid_w, decide_w, bit_w;

  assign mid_w = (timer_q == 14'd0);

`ifdef UART_RX_MAJORITY_EN
  localparam logic [13:0] EARLY_AT  = 14'(SAMPLE_OFFSET);
  localparam logic [13:0] DECIDE_AT = 14'(CYCLES_PER_BIT - SAMPLE_OFFSET);

  logic early_q, center_q, pend_q;

  // The timer keeps running from the nominal mid-bit, so the late decision never shifts later bits.
  assign decide_w = pend_q && (timer_q == DECIDE_AT);
  assign bit_w    = (early_q & center_q) | (early_q & rxs_q) | (center_q & rxs_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      early_q  <= 1'b1;
      center_q <= 1'b1;
      pend_q   <= 1'b0;
    end else if (state_q inside {START, DATA, STOP}) begin
      if (timer_q == EARLY_AT) early_q <= rxs_q;
      if (mid_w) begin
        center_q <= rxs_q;
        pend_q   <= 1'b1;
      end else if (decide_w) begin
        pend_q <= 1'b0;
      end
    end else begin
      pend_q <= 1'b0;
    end
  end
`else
  assign decide_w = mid_w;
  assign bit_w    = rxs_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
      timer_q    <= 14'd0;
      idx_q      <= 3'd0;
      shift_q    <= 8'h00;
      data_q     <= 8'h00;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      sync1_q    <= Rxd;
      rxs_q      <= sync1_q;
      rxs_prev_q <= rxs_q;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
      if (valid_q && rx_ack) valid_q <= 1'b0;
      if (state_q inside {START, DATA, STOP})
        timer_q <= mid_w ? BIT_RELOAD : timer_q - 14'd1;

      case (state_q)
        IDLE: begin
          if (rxs_prev_q && !rxs_q) begin
            timer_q <= HALF_RELOAD;
            state_q <= START;
          end
        end
        START: begin
          if (decide_w) begin
            if (bit_w) begin
              state_q <= IDLE;
            end else begin
              idx_q   <= 3'd0;
              state_q <= DATA;
            end
          end
        end
        DATA: begin
          if (decide_w) begin
            shift_q <= {bit_w, shift_q[7:1]};
            idx_q   <= idx_q + 3'd1;
            if (idx_q == 3'd7) state_q <= STOP;
          end
        end
        STOP: begin
          if (decide_w) begin
            if (bit_w) begin
              // A same-cycle ack frees the holding register for the new byte.
              if (!valid_q || rx_ack) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
              end else begin
                ovr_q <= 1'b1;
              end
              state_q <= IDLE;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= BREAK;
            end
          end
        end
        BREAK: begin
          if (rxs_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_byte_rx.sv
// tb/tb_uart_byte_rx.sv - randomized scoreboard bench for uart_byte_rx
module tb_uart_byte_rx;

  localparam int C   = 160;
  localparam int H   = C / 2;
  localparam int OFF = C / 16;
`ifdef UART_RX_MAJORITY_EN
  localparam int LAT = 2 + H + 9 * C + 1 + OFF;
`else
  localparam int LAT = 2 + H + 9 * C + 1;
`endif

  logic       clk;
  logic       rst;
  logic       Rxd;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int         checks = 0;
  int         passes = 0;
  logic [7:0] exp_q[$];
  int         exp_ferr = 0, exp_ovr = 0;
  int         ferr_cnt = 0, ovr_cnt = 0;
  bit         m_held = 0;
  bit         auto_ack = 0;
  int         lat;
  logic [9:0] fb;
  logic [7:0] rd;

  uart_byte_rx #(.CYCLES_PER_BIT(C)) dut (
    .clk      (clk),
    .rst      (rst),
    .Rxd      (Rxd),
    .rx_ack   (rx_ack),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference model: a good frame is delivered unless a byte is still held, in which case it overruns.
  task automatic model_frame(input logic [7:0] d, input bit stop_ok, input bit prev_acked);
    if (prev_acked) m_held = 0;
    if (!stop_ok) exp_ferr++;
    else if (m_held) exp_ovr++;
    else begin
      exp_q.push_back(d);
      m_held = 1;
    end
  endtask

  task automatic clks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_val, input int glitch_bit);
    logic [9:0] bits;
    bits = {stop_val, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      Rxd = bits[i];
      for (int c = 0; c < C; c++) begin
        if (glitch_bit >= 0 && i == glitch_bit + 1 && c == H - 1) Rxd = 1'b0;
        if (glitch_bit >= 0 && i == glitch_bit + 1 && c == H + 4) Rxd = bits[i];
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic tx(input logic [7:0] d, input int gap);
    model_frame(d, 1'b1, 1'b1);
    send_frame(d, 1'b1, -1);
    Rxd = 1'b1;
    clks(gap);
  endtask

  task automatic do_ack();
    rx_ack = 1'b1;
    clks(1);
    rx_ack = 1'b0;
    m_held = 0;
  endtask

  // Monitor: a delivery is rx_valid rising, or rx_valid staying high right after an accepted ack.
  initial begin
    bit pv, pa;
    pv = 0;
    pa = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pv = 0;
        pa = 0;
      end else begin
        if (frame_err) ferr_cnt++;
        if (overrun) ovr_cnt++;
        if (rx_valid && (!pv || pa)) begin
          if (exp_q.size() == 0) check("unexpected_byte", int'(rx_data), -1);
          else check("rx_data", int'(rx_data), int'(exp_q.pop_front()));
        end
        pv = rx_valid;
        pa = rx_ack;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (auto_ack && rst && rx_valid && !rx_ack) begin
        @(posedge clk);
        #1 rx_ack = 1'b1;
        @(posedge clk);
        #1 rx_ack = 1'b0;
      end
    end
  end

  initial begin
    rst    = 1'b0;
    Rxd    = 1'b1;
    rx_ack = 1'b0;
    #1;
    check("reset_rx_data", int'(rx_data), 0);
    check("reset_rx_valid", int'(rx_valid), 0);
    check("reset_frame_err", int'(frame_err), 0);
    check("reset_overrun", int'(overrun), 0);
    check("reset_busy", int'(busy), 0);
    clks(4);
    rst = 1'b1;
    clks(4);

    // Latency of a single frame and ack clearing rx_valid
    model_frame(8'hA5, 1'b1, 1'b0);
    lat = 0;
    fork
      send_frame(8'hA5, 1'b1, -1);
      begin
        for (int n = 1; n <= LAT + 3; n++) begin
          @(posedge clk);
          #1;
          if (rx_valid && lat == 0) lat = n;
        end
      end
    join
    Rxd = 1'b1;
    checks++;
    if (lat >= LAT - 1 && lat <= LAT + 1) passes++;
    else $display("FAIL latency: got %0d expected %0d +-1", lat, LAT);
    do_ack();
    check("ack_clears_valid", int'(rx_valid), 0);
    check("ack_keeps_data", int'(rx_data), 8'hA5);

    // Back-to-back frames
    auto_ack = 1;
    model_frame(8'h00, 1'b1, 1'b1);
    model_frame(8'hFF, 1'b1, 1'b1);
    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    Rxd = 1'b1;
    clks(C);
    check("b2b_frame_err", ferr_cnt, exp_ferr);
    check("b2b_overrun", ovr_cnt, exp_ovr);

    // Short low pulse is a false start
    Rxd = 1'b0;
    clks(H / 2);
    check("false_start_busy", int'(busy), 1);
    Rxd = 1'b1;
    clks(C);
    check("false_start_idle", int'(busy), 0);
    check("false_start_ferr", ferr_cnt, exp_ferr);
    tx(8'h3C, C);

    // Low stop bit followed by a held-low line
    model_frame(8'h81, 1'b0, 1'b1);
    send_frame(8'h81, 1'b0, -1);
    clks(5 * C);
    Rxd = 1'b1;
    clks(C);
    check("break_frame_err", ferr_cnt, exp_ferr);
    check("break_no_valid", int'(rx_valid), 0);
    check("break_idle", int'(busy), 0);
    tx(8'h42, C);

    // Overrun, then an ack landing in the completion cycle
    auto_ack = 0;
    clks(C);
    tx(8'h11, C / 4);
    model_frame(8'h22, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, -1);
    Rxd = 1'b1;
    clks(C);
    check("overrun_count", ovr_cnt, exp_ovr);
    check("overrun_keeps_data", int'(rx_data), 8'h11);
    check("overrun_keeps_valid", int'(rx_valid), 1);
    model_frame(8'h22, 1'b1, 1'b1);
    fork
      send_frame(8'h22, 1'b1, -1);
      begin
        clks(LAT - 1);
        rx_ack = 1'b1;
        clks(1);
        rx_ack = 1'b0;
      end
    join
    Rxd = 1'b1;
    clks(C);
    check("ack_at_completion_data", int'(rx_data), 8'h22);
    check("ack_at_completion_no_ovr", ovr_cnt, exp_ovr);

    // Asynchronous reset during data bit 4
    fb = {1'b1, 8'h5A, 1'b0};
    for (int i = 0; i < 5; i++) begin
      Rxd = fb[i];
      clks(C);
    end
    Rxd = fb[5];
    clks(H);
    rst = 1'b0;
    #1;
    m_held = 0;
    check("midrst_rx_data", int'(rx_data), 0);
    check("midrst_rx_valid", int'(rx_valid), 0);
    check("midrst_frame_err", int'(frame_err), 0);
    check("midrst_overrun", int'(overrun), 0);
    check("midrst_busy", int'(busy), 0);
    Rxd = 1'b1;
    clks(4);
    rst = 1'b1;
    clks(4);
    auto_ack = 1;
    tx(8'h5A, C);

    // Random bytes with random idle gaps
    for (int k = 0; k < 6; k++) begin
      rd = 8'($urandom_range(0, 255));
      tx(rd, int'($urandom_range(0, C)));
    end

`ifdef UART_RX_MAJORITY_EN
    model_frame(8'hFF, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 3);
    Rxd = 1'b1;
    clks(C);
`endif

    clks(2 * C);
    check("all_bytes_delivered", exp_q.size(), 0);
    check("total_frame_err", ferr_cnt, exp_ferr);
    check("total_overrun", ovr_cnt, exp_ovr);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
